// File: rtl/serial_adder_if.sv
// Operand/result bundle between an issuing controller (master) and the
// bit-serial adder (slave).
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop process the
// operands LSB first, one bit per clock, with a start/busy/done handshake.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LAST = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] sum_q, sum_n;
  logic             c, c_n;
  logic             cout_q, cout_n;
  logic             busy_q, done_q;
  logic [CW-1:0]    cnt, cnt_n;
  logic             s, co;

  // Single full-adder cell on the current LSBs
  assign s  = sa[0] ^ sb[0] ^ c;
  assign co = (sa[0] & sb[0]) | (c & (sa[0] ^ sb[0]));

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    acc_n   = acc;
    c_n     = c;
    cnt_n   = cnt;
    sum_n   = sum_q;
    cout_n  = cout_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          c_n     = bus.cin;
          cnt_n   = '0;
          acc_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        c_n   = co;
        acc_n = {s, acc[WIDTH-1:1]};
        sa_n  = {1'b0, sa[WIDTH-1:1]};
        sb_n  = {1'b0, sb[WIDTH-1:1]};
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(LAST)) begin
          sum_n   = {s, acc[WIDTH-1:1]};
          cout_n  = co;
          state_n = DONE;
        end
      end
      DONE: begin
        // The edge leaving DONE is the earliest issue point, so a start
        // sampled here begins the next operation back-to-back.
        if (bus.start) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          c_n     = bus.cin;
          cnt_n   = '0;
          acc_n   = '0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      sa     <= sa_n;
      sb     <= sb_n;
      acc    <= acc_n;
      c      <= c_n;
      cnt    <= cnt_n;
      sum_q  <= sum_n;
      cout_q <= cout_n;
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8: latency, results,
// start-ignore while busy, reset abort and back-to-back issue.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] prev_sum  = 8'h00;
  logic       prev_cout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Issue one operation from IDLE (called #1 after an edge) and check it
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] es, input logic eco, input string name);
    int  lat;
    bit  busy_ok;
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 4) check({name, "_held_sum"}, 32'(bus.sum), 32'(prev_sum));
    end
    check({name, "_latency"}, 32'(lat), 32'(WIDTH));
    check({name, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({name, "_sum"}, 32'(bus.sum), 32'(es));
    check({name, "_cout"}, 32'(bus.cout), 32'(eco));
    @(posedge clk); #1;
    check({name, "_done_clr"}, 32'(bus.done), 32'd0);
    check({name, "_busy_clr"}, 32'(bus.busy), 32'd0);
    prev_sum  = es;
    prev_cout = eco;
  endtask

  initial begin
    vecs[0] = '{a: 8'h3C, b: 8'h0F, cin: 1'b0, s: 8'h4B, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, co: 1'b1};
    vecs[6] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, co: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, co: 1'b0};

    // Reset with start held high: nothing may be accepted
    rst = 1'b1;
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h22; bus.cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_release_start_ignored", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // Start pulses at cycles 3 and 8 of a running op must be ignored
    begin
      int  ndone;
      bit  busy_ok;
      bus.a = 8'h11; bus.b = 8'h22; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      ndone = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= WIDTH; k++) begin
        bus.start = (k == 3 || k == 8);
        bus.a = 8'hF0; bus.b = 8'hF0; bus.cin = 1'b1;
        @(posedge clk); #1;
        if (bus.done === 1'b1) ndone++;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
      end
      bus.start = 1'b0;
      check("ign_sum", 32'(bus.sum), 32'h33);
      check("ign_done_at_8", 32'(bus.done), 32'd1);
      for (int k = 0; k < WIDTH + 2; k++) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1) ndone++;
      end
      check("ign_single_done", 32'(ndone), 32'd1);
      check("ign_busy_run", 32'(busy_ok), 32'd1);
      check("ign_idle_after", 32'(bus.busy), 32'd0);
      prev_sum = 8'h33; prev_cout = 1'b0;
    end

    // Reset abort while bit 4 of 0x80+0x80 is being processed
    begin
      int ndone;
      bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_sum",  32'(bus.sum),  32'd0);
      check("abort_cout", 32'(bus.cout), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < WIDTH + 3; k++) begin
        @(posedge clk); #1;
        if (bus.done === 1'b1) ndone++;
      end
      check("abort_no_done", 32'(ndone), 32'd0);
      prev_sum = 8'h00; prev_cout = 1'b0;
      do_op(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, "post_abort");
    end

    // Back-to-back sweep with start held high
    begin
      logic [7:0] ca, cb;
      logic       cc;
      logic [8:0] exp;
      int         lat;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
      bus.start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
        ca = bus.a; cb = bus.b; cc = bus.cin;
        exp = 9'(ca) + 9'(cb) + 9'(cc);
        bus.a = 8'($urandom); bus.b = 8'($urandom); bus.cin = 1'($urandom);
        lat = 0;
        for (int k = 1; k <= WIDTH + 2; k++) begin
          @(posedge clk); #1;
          if (bus.done === 1'b1) begin
            lat = k;
            break;
          end
        end
        check($sformatf("sweep%0d_latency", i), 32'(lat), 32'(WIDTH));
        check($sformatf("sweep%0d_result", i), 32'({bus.cout, bus.sum}), 32'(exp));
        if (i == 999) bus.start = 1'b0;
        @(posedge clk); #1;
      end
      check("sweep_idle_after", 32'(bus.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
